bist_mem_responder: RTL and testbench
=====================================

Name: bist_mem_responder

Overview:
- Memory-side responder for the BIST engine. It serves single-word read/write requests over a req/ack handshake, with a configurable read latency.
- It has a built-in stuck-at fault injector, so the BIST FSM/comparator path can be exercised against a deliberately broken memory.
- Sits between the BIST address/data generators and the storage array, as a drop-in, latency-realistic memory model.

Parameters:
- data_width, 4, word width in bits
- ad_width, 4, address width; depth = 2**ad_width words
- rd_latency, 2, read request-to-data cycles; legal range 1..4

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  1  request strobe; accepted at a rising edge when busy=0
- we  in  1  1=write, 0=read; sampled with req
- addr  in  ad_width  word address; sampled with req
- din  in  data_width  write data; sampled with req
- fault_en  in  1  enable stuck-at injection
- fault_addr  in  ad_width  faulty word address
- fault_bit  in  clog2(data_width)  faulty bit index
- fault_val  in  1  stuck-at value
- ack  out  1  one-cycle completion pulse
- rvalid  out  1  rdata valid; one-cycle pulse, reads only
- rdata  out  data_width  read data; holds last value between reads
- busy  out  1  request in progress; req ignored while 1

Behaviour:
- Cycle numbering: accept edge E0 = rising edge with req=1, busy=0, rst=1. "Cycle k" = interval after edge Ek.
- Reset (rst=0, asynchronous): state=IDLE; ack=0, rvalid=0, busy=0, rdata=0. All storage words cleared to 0. Any pending read is dropped with no ack. Outputs stay at reset values until the first edge after rst deasserts.
- States:
  - IDLE: accepts requests.
  - RD_WAIT: counter from rd_latency-1 down to 1.
  - RESP: ack/rvalid cycle.
- Write, accepted at E0:
  - mem[addr] <= din at E0.
  - ack=1 in cycle 0; busy=0 in cycle 0.
  - Back-to-back writes are possible at one per cycle.
- Read, accepted at E0:
  - addr and fault_* are captured at E0; the word is read from storage at E0.
  - ack=1, rvalid=1, rdata valid in cycle L-1, where L=rd_latency. busy=1 in cycles 0..L-2, 0 in cycle L-1.
  - L=1: data in cycle 0, same timing as a write. L=1 bypasses RD_WAIT.
  - Next request can be accepted at edge E(L).
- Fault injection:
  - Applies when fault_en=1 and captured addr==fault_addr.
  - Returned rdata bit fault_bit is forced to fault_val; all other bits pass through.
  - Stored contents are never altered by the injector.
  - fault_bit >= data_width: no effect.
- req while busy=1: ignored, no queueing, no side effect. The requester must hold req until it sees busy=0 at an edge.
- rdata:
  - Updated only in RESP of a read.
  - Unchanged by writes.
  - Unchanged during cycles with rvalid=0.
- ack and rvalid are never high for more than one consecutive cycle per request. rvalid=1 implies ack=1.
- Address covers the full 2**ad_width range; no out-of-range case.
- Transitions:
  - IDLE->IDLE on write or L=1 read (ack cycle is output-registered).
  - IDLE->RD_WAIT on read with L>=2.
  - RD_WAIT->RESP when counter reaches 1.
  - RESP->IDLE.

Test Plan:
- Reset/clear: drive rst=0 mid-read (L=2, after E0), release, read addr 5 -> no ack for the aborted read; the new read returns rdata=0 with ack=rvalid=1 exactly in cycle 1.
- Write/read, L=2: write 4'hA to addr 3 (ack in cycle 0), then read addr 3 -> busy=1 in cycle 0; ack=rvalid=1, rdata=4'hA in cycle 1.
- Latency sweep: rd_latency=1 and 4, read addr 7 holding 4'h6 -> rvalid in cycle 0 (L=1) and in cycle 3 (L=4); busy low exactly in the rvalid cycle.
- Busy rejection, L=3: hold req=1, we=1, din=4'hF, addr=2 during an outstanding read of addr 2 (stored 4'h1) -> read returns 4'h1; write is accepted only at edge E3, then a read of addr 2 returns 4'hF.
- Fault injection: mem[9]=4'h0, fault_en=1, fault_addr=9, fault_bit=2, fault_val=1 -> read 9 gives 4'h4, read 8 unaffected. With fault_en=0, read 9 gives 4'h0, confirming storage is unmodified.
- Full sweep: write addr^4'h5 to all 16 addresses back-to-back (16 consecutive acks), read all back -> every rdata matches and exactly 16 rvalid pulses are seen.

Source files
------------

// File: rtl/bist_mem_responder.sv
// bist_mem_responder: memory-side responder for the BIST engine.
// Serves single-word read/write requests over a req/ack handshake with a
// configurable read latency. A stuck-at injector corrupts one bit of the
// returned read word so the BIST comparator path can be exercised. The
// injector never modifies the stored contents.

module bist_mem_responder #(
   parameter int data_width = 4,
   parameter int ad_width   = 4,
   parameter int rd_latency = 2,
   localparam int fb_width  = (data_width > 1) ? $clog2(data_width) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  we,
   input  logic [ad_width-1:0]   addr,
   input  logic [data_width-1:0] din,
   input  logic                  fault_en,
   input  logic [ad_width-1:0]   fault_addr,
   input  logic [fb_width-1:0]   fault_bit,
   input  logic                  fault_val,
   output logic                  ack,
   output logic                  rvalid,
   output logic [data_width-1:0] rdata,
   output logic                  busy
);

   localparam int depth = 2 ** ad_width;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RESP    = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [2:0]            cnt_q;
   logic [data_width-1:0] mem [depth];
   logic [data_width-1:0] read_word;
   logic [data_width-1:0] hold_q;
   logic                  fault_hit;
   logic                  accept;
   logic                  acc_wr;
   logic                  acc_rd;

   // Only the wait phase of a multi-cycle read blocks new requests; the
   // response cycle itself can already accept the next request.
   assign busy   = (state_q == RD_WAIT);
   assign accept = req && !busy;
   assign acc_wr = accept && we;
   assign acc_rd = accept && !we;

   // An out-of-range bit index leaves the word untouched.
   assign fault_hit = fault_en && (fault_addr == addr) && (int'(fault_bit) < data_width);

   // Word returned for a read accepted this cycle, with the stuck-at bit applied.
   always_comb begin
      read_word = mem[addr];
      if (fault_hit) begin
         read_word[fault_bit] = fault_val;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: IDLE and RESP both accept requests; only reads longer than one cycle wait.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, RESP: begin
            state_d = IDLE;
            if (acc_rd && (rd_latency > 1)) begin
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (cnt_q == 3'd1) begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Storage array; cleared by reset, written on an accepted write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < depth; i++) begin
            mem[i] <= '0;
         end
      end else if (acc_wr) begin
         mem[addr] <= din;
      end
   end

   // Handshake outputs, latency counter and read data capture/return.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack    <= 1'b0;
         rvalid <= 1'b0;
         rdata  <= '0;
         hold_q <= '0;
         cnt_q  <= '0;
      end else begin
         ack    <= 1'b0;
         rvalid <= 1'b0;
         if (acc_wr) begin
            ack <= 1'b1;
         end
         if (acc_rd) begin
            if (rd_latency == 1) begin
               rdata  <= read_word;
               ack    <= 1'b1;
               rvalid <= 1'b1;
            end else begin
               hold_q <= read_word;
               cnt_q  <= 3'(rd_latency - 1);
            end
         end
         if (state_q == RD_WAIT) begin
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               rdata  <= hold_q;
               ack    <= 1'b1;
               rvalid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bist_mem_responder.sv
// tb_bist_mem_responder: directed bench for bist_mem_responder.
// Four responders with read latencies 1..4 share all inputs except req.
// Expected read words come from a bench-side memory/fault model, are queued
// when a read is issued and popped when the responder raises rvalid.

module tb_bist_mem_responder;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       we;
   logic [3:0] addr;
   logic [3:0] din;
   logic       fault_en;
   logic [3:0] fault_addr;
   logic [1:0] fault_bit;
   logic       fault_val;
   logic [3:0] ack;
   logic [3:0] rvalid;
   logic [3:0] busy;
   logic [3:0] rdata [4];

   logic [3:0] model_mem [4][16];
   logic [3:0] last_rdata [4];
   logic [3:0] exp_q [$];
   int         n_asserts;
   int         n_fails;
   int         ack_count;
   int         rvalid_count;

   // Instance g has read latency g+1.
   for (genvar g = 0; g < 4; g++) begin : g_dut
      bist_mem_responder #(
         .data_width(4),
         .ad_width  (4),
         .rd_latency(g + 1)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .req       (req[g]),
         .we        (we),
         .addr      (addr),
         .din       (din),
         .fault_en  (fault_en),
         .fault_addr(fault_addr),
         .fault_bit (fault_bit),
         .fault_val (fault_val),
         .ack       (ack[g]),
         .rvalid    (rvalid[g]),
         .rdata     (rdata[g]),
         .busy      (busy[g])
      );
   end

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_asserts++;
      assert (observed === expected)
      else begin
         n_fails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int d, input logic w, input logic [3:0] a, input logic [3:0] v);
      req[d] = 1'b1;
      we     = w;
      addr   = a;
      din    = v;
   endtask

   function automatic logic [3:0] modelRead(input int d, input logic [3:0] a);
      logic [3:0] w;
      w = model_mem[d][a];
      if (fault_en && (fault_addr == a) && (int'(fault_bit) < 4)) begin
         w[fault_bit] = fault_val;
      end
      return w;
   endfunction

   task automatic clearModel();
      for (int d = 0; d < 4; d++) begin
         last_rdata[d] = 4'h0;
         for (int a = 0; a < 16; a++) begin
            model_mem[d][a] = 4'h0;
         end
      end
   endtask

   // One write: ack in cycle 0, never busy, rdata untouched.
   task automatic doWrite(input int d, input logic [3:0] a, input logic [3:0] v);
      applyStimulus(d, 1'b1, a, v);
      tick();
      req[d] = 1'b0;
      we     = 1'b0;
      model_mem[d][a] = v;
      if (ack[d]) ack_count++;
      checkOutput($sformatf("wr_hs_d%0d_a%0h", d, a), 32'({ack[d], rvalid[d], busy[d]}), 32'(3'b100));
      checkOutput($sformatf("wr_rdata_hold_d%0d", d), 32'(rdata[d]), 32'(last_rdata[d]));
   endtask

   // Observes one cycle of an outstanding read; pops the scoreboard on rvalid.
   task automatic observeRead(input int d, input string tag, input logic [2:0] exp_hs);
      checkOutput(tag, 32'({ack[d], rvalid[d], busy[d]}), 32'(exp_hs));
      if (rvalid[d]) begin
         rvalid_count++;
         checkOutput({tag, "_pending"}, 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            last_rdata[d] = exp_q.pop_front();
            checkOutput({tag, "_data"}, 32'(rdata[d]), 32'(last_rdata[d]));
         end
      end else begin
         checkOutput({tag, "_hold"}, 32'(rdata[d]), 32'(last_rdata[d]));
      end
   endtask

   // One read on instance d (latency d+1), watched up to one cycle past the response.
   task automatic doRead(input int d, input logic [3:0] a);
      int L;
      L = d + 1;
      exp_q.push_back(modelRead(d, a));
      applyStimulus(d, 1'b0, a, 4'h0);
      tick();
      req[d] = 1'b0;
      for (int k = 0; k <= L; k++) begin
         observeRead(d, $sformatf("rd_L%0d_a%0h_c%0d", L, a, k),
                     (k == L - 1) ? 3'b110 : ((k < L - 1) ? 3'b001 : 3'b000));
         if (k < L) tick();
      end
      checkOutput($sformatf("rd_L%0d_a%0h_drained", L, a), 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // Directed sequence.
   initial begin
      n_asserts    = 0;
      n_fails      = 0;
      ack_count    = 0;
      rvalid_count = 0;
      rst          = 1'b0;
      req          = 4'h0;
      we           = 1'b0;
      addr         = 4'h0;
      din          = 4'h0;
      fault_en     = 1'b0;
      fault_addr   = 4'h0;
      fault_bit    = 2'd0;
      fault_val    = 1'b0;
      clearModel();

      $display("[TB] reset state");
      repeat (2) tick();
      for (int d = 0; d < 4; d++) begin
         checkOutput($sformatf("reset_hs_d%0d", d), 32'({ack[d], rvalid[d], busy[d]}), 32'(3'b000));
         checkOutput($sformatf("reset_rdata_d%0d", d), 32'(rdata[d]), 32'd0);
      end
      rst = 1'b1;
      tick();

      $display("[TB] reset aborts a pending read and clears storage");
      doWrite(1, 4'h5, 4'hC);
      applyStimulus(1, 1'b0, 4'h5, 4'h0);
      tick();
      req[1] = 1'b0;
      checkOutput("abort_busy_c0", 32'(busy[1]), 32'd1);
      #2 rst = 1'b0;
      #1;
      checkOutput("abort_async_hs", 32'({ack[1], rvalid[1], busy[1]}), 32'(3'b000));
      tick();
      rst = 1'b1;
      clearModel();
      for (int k = 0; k < 2; k++) begin
         tick();
         checkOutput($sformatf("abort_no_ack_%0d", k), 32'({ack[1], rvalid[1]}), 32'(2'b00));
      end
      doRead(1, 4'h5);

      $display("[TB] write then read, latency 2");
      doWrite(1, 4'h3, 4'hA);
      doRead(1, 4'h3);

      $display("[TB] latency sweep");
      doWrite(0, 4'h7, 4'h6);
      doRead(0, 4'h7);
      doWrite(3, 4'h7, 4'h6);
      doRead(3, 4'h7);

      $display("[TB] busy rejection, latency 3");
      doWrite(2, 4'h2, 4'h1);
      exp_q.push_back(modelRead(2, 4'h2));
      applyStimulus(2, 1'b0, 4'h2, 4'h0);
      tick();
      we  = 1'b1;
      din = 4'hF;
      observeRead(2, "busy_rej_c0", 3'b001);
      tick();
      observeRead(2, "busy_rej_c1", 3'b001);
      tick();
      observeRead(2, "busy_rej_c2", 3'b110);
      tick();
      req[2] = 1'b0;
      we     = 1'b0;
      model_mem[2][2] = 4'hF;
      checkOutput("busy_rej_wr_ack_c3", 32'({ack[2], rvalid[2], busy[2]}), 32'(3'b100));
      checkOutput("busy_rej_rdata_c3", 32'(rdata[2]), 32'(last_rdata[2]));
      tick();
      checkOutput("busy_rej_idle_c4", 32'({ack[2], rvalid[2], busy[2]}), 32'(3'b000));
      doRead(2, 4'h2);

      $display("[TB] fault injection");
      doWrite(1, 4'h9, 4'h0);
      doWrite(1, 4'h8, 4'hB);
      fault_en   = 1'b1;
      fault_addr = 4'h9;
      fault_bit  = 2'd2;
      fault_val  = 1'b1;
      doRead(1, 4'h9);
      doRead(1, 4'h8);
      fault_en = 1'b0;
      doRead(1, 4'h9);
      doWrite(1, 4'h9, 4'hF);
      fault_en  = 1'b1;
      fault_bit = 2'd0;
      fault_val = 1'b0;
      doRead(1, 4'h9);
      doRead(0, 4'h9);
      fault_en = 1'b0;
      doRead(1, 4'h9);

      $display("[TB] full sweep");
      ack_count = 0;
      for (int a = 0; a < 16; a++) begin
         doWrite(1, 4'(a), 4'(a) ^ 4'h5);
      end
      checkOutput("sweep_ack_count", 32'(ack_count), 32'd16);
      rvalid_count = 0;
      for (int a = 0; a < 16; a++) begin
         doRead(1, 4'(a));
      end
      checkOutput("sweep_rvalid_count", 32'(rvalid_count), 32'd16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
